// File: rtl/gsens_mark_draw_if.sv
// Write-bus control handshake between the frame arbiter and a drawing source.
interface gsens_mark_draw_if #(
  parameter int unsigned SEL_WIDTH = 2
);
  logic [SEL_WIDTH-1:0] write_source_sel;
  logic                 write_awaited;
  logic                 frame_done;

  modport master (
    output write_source_sel,
    output write_awaited,
    input  frame_done
  );

  modport slave (
    input  write_source_sel,
    input  write_awaited,
    output frame_done
  );
endinterface

// File: rtl/gsens_mark_draw.sv
// Draws a full frame with a centre crosshair and one square mark per tilt channel,
// offset from the frame centre by the latched tilt magnitude and direction.
module gsens_mark_draw #(
  parameter int unsigned SOURCE_ID   = 0,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned COLOR_DEPTH = 9,
  parameter int unsigned DRAW_WIDTH  = 640,
  parameter int unsigned DRAW_HEIGHT = 480,
  parameter int unsigned NUM_MARKS   = 2,
  parameter int unsigned TILT_WIDTH  = 4,
  parameter int unsigned TILT_SCALE  = 1,
  parameter int unsigned MARK_SIZE   = 10,
  parameter logic [COLOR_DEPTH-1:0] CROSS_COLOR = '1,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR    = '0
) (
  input  logic                             clk,
  input  logic                             resetN,
  gsens_mark_draw_if.slave                 bus,
  input  logic [NUM_MARKS*TILT_WIDTH-1:0]  tilt_amount_x,
  input  logic [NUM_MARKS-1:0]             tilt_direction_x,
  input  logic [NUM_MARKS*TILT_WIDTH-1:0]  tilt_amount_y,
  input  logic [NUM_MARKS-1:0]             tilt_direction_y,
  input  logic [NUM_MARKS-1:0]             mark_enable,
  input  logic [NUM_MARKS*COLOR_DEPTH-1:0] mark_color,
  output logic                             write_active,
  output logic [COLOR_DEPTH-1:0]           write_color_data,
  output logic [31:0]                      write_x_addr,
  output logic [31:0]                      write_y_addr
);

  localparam int unsigned COL_W = $clog2(DRAW_WIDTH);
  localparam int unsigned ROW_W = $clog2(DRAW_HEIGHT);

  typedef logic signed [15:0] coord_t;

  localparam coord_t HALF_W = coord_t'(DRAW_WIDTH / 2);
  localparam coord_t HALF_H = coord_t'(DRAW_HEIGHT / 2);
  localparam coord_t MS     = coord_t'(MARK_SIZE);
  localparam coord_t HI_X   = coord_t'(DRAW_WIDTH - 1 - MARK_SIZE);
  localparam coord_t HI_Y   = coord_t'(DRAW_HEIGHT - 1 - MARK_SIZE);

  typedef enum logic [1:0] {StIdle, StLatch, StWrite, StDone} state_t;

  state_t r_state, w_state_d;

  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  coord_t                       r_cx [NUM_MARKS];
  coord_t                       r_cy [NUM_MARKS];
  logic [NUM_MARKS-1:0]         r_en;
  logic [NUM_MARKS*COLOR_DEPTH-1:0] r_mcolor;

  logic                   r_active;
  logic [COL_W-1:0]       r_x;
  logic [ROW_W-1:0]       r_y;
  logic [COLOR_DEPTH-1:0] r_color;
  logic                   r_frame_done;

  logic                   w_sel;
  logic                   w_last;
  logic                   w_pix_valid;
  logic                   w_cross;
  coord_t                 w_col_s;
  coord_t                 w_row_s;
  coord_t                 w_cx [NUM_MARKS];
  coord_t                 w_cy [NUM_MARKS];
  logic [NUM_MARKS-1:0]   w_hit;
  logic [COLOR_DEPTH-1:0] w_color;

  function automatic coord_t centre(input coord_t half, input coord_t hi,
                                    input logic [TILT_WIDTH-1:0] amt, input logic dir);
    coord_t mag, raw;
    mag = coord_t'(amt) << TILT_SCALE;
    raw = dir ? half + mag : half - mag;
    if (raw < MS)      return MS;
    else if (raw > hi) return hi;
    else               return raw;
  endfunction

  assign w_sel       = (bus.write_source_sel == SEL_WIDTH'(SOURCE_ID));
  assign w_last      = (r_col == COL_W'(DRAW_WIDTH - 1)) && (r_row == ROW_W'(DRAW_HEIGHT - 1));
  assign w_pix_valid = (r_state == StWrite) && w_sel;
  assign w_col_s     = coord_t'(r_col);
  assign w_row_s     = coord_t'(r_row);
  assign w_cross     = (r_col == COL_W'(DRAW_WIDTH / 2 - 1)) || (r_col == COL_W'(DRAW_WIDTH / 2)) ||
                       (r_row == ROW_W'(DRAW_HEIGHT / 2 - 1)) || (r_row == ROW_W'(DRAW_HEIGHT / 2));

  for (genvar i = 0; i < NUM_MARKS; i++) begin : g_mark
    coord_t w_dx, w_dy;
    assign w_cx[i]  = centre(HALF_W, HI_X, tilt_amount_x[i*TILT_WIDTH +: TILT_WIDTH],
                             tilt_direction_x[i]);
    assign w_cy[i]  = centre(HALF_H, HI_Y, tilt_amount_y[i*TILT_WIDTH +: TILT_WIDTH],
                             tilt_direction_y[i]);
    assign w_dx     = w_col_s - r_cx[i];
    assign w_dy     = w_row_s - r_cy[i];
    assign w_hit[i] = r_en[i] && (w_dx >= -MS) && (w_dx <= MS) && (w_dy >= -MS) && (w_dy <= MS);
  end

  // Walk channels from highest to lowest so the lowest enabled hit wins.
  always_comb begin
    w_color = w_cross ? CROSS_COLOR : BG_COLOR;
    for (int i = NUM_MARKS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_color = r_mcolor[i*COLOR_DEPTH +: COLOR_DEPTH];
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.write_awaited && w_sel) w_state_d = StLatch;
      StLatch: w_state_d = w_sel ? StWrite : StIdle;
      StWrite: begin
        if (!w_sel)      w_state_d = StIdle;
        else if (w_last) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_col    <= '0;
      r_row    <= '0;
      r_en     <= '0;
      r_mcolor <= '0;
      for (int i = 0; i < NUM_MARKS; i++) begin
        r_cx[i] <= HALF_W;
        r_cy[i] <= HALF_H;
      end
    end else if (r_state == StLatch) begin
      r_col    <= '0;
      r_row    <= '0;
      r_en     <= mark_enable;
      r_mcolor <= mark_color;
      for (int i = 0; i < NUM_MARKS; i++) begin
        r_cx[i] <= w_cx[i];
        r_cy[i] <= w_cy[i];
      end
    end else if (w_pix_valid && !w_last) begin
      if (r_col == COL_W'(DRAW_WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Address and colour are registered together so they always describe one pixel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_active     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_color      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_active     <= w_pix_valid;
      r_x          <= w_pix_valid ? r_col : '0;
      r_y          <= w_pix_valid ? r_row : '0;
      r_color      <= w_pix_valid ? w_color : '0;
      r_frame_done <= (r_state == StDone);
    end
  end

  assign write_active     = w_sel ? r_active : 1'bz;
  assign write_color_data = w_sel ? r_color : {COLOR_DEPTH{1'bz}};
  assign write_x_addr     = w_sel ? 32'(r_x) : {32{1'bz}};
  assign write_y_addr     = w_sel ? 32'(r_y) : {32{1'bz}};
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_gsens_mark_draw.sv
// Directed bench for gsens_mark_draw on a reduced 64x48 frame; a negedge monitor
// captures every active pixel into a frame store that the directed checks inspect.
module tb_gsens_mark_draw;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int NP = W * H;
  localparam logic [8:0] CROSS = 9'h1FF;
  localparam logic [8:0] BG    = 9'h000;
  localparam logic [8:0] C0    = 9'h0AA;
  localparam logic [8:0] C1    = 9'h133;
  localparam logic [8:0] UNSET = 9'h0F5;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  gsens_mark_draw_if #(.SEL_WIDTH(2)) bus ();

  logic [7:0]  tax, tay;
  logic [1:0]  tdx, tdy, men;
  logic [17:0] mcol;
  wire         wa;
  wire  [8:0]  wc;
  wire  [31:0] wx, wy;

  gsens_mark_draw #(
    .DRAW_WIDTH (W),
    .DRAW_HEIGHT(H)
  ) u_dut (
    .clk             (clk),
    .resetN          (resetN),
    .bus             (bus),
    .tilt_amount_x   (tax),
    .tilt_direction_x(tdx),
    .tilt_amount_y   (tay),
    .tilt_direction_y(tdy),
    .mark_enable     (men),
    .mark_color      (mcol),
    .write_active    (wa),
    .write_color_data(wc),
    .write_x_addr    (wx),
    .write_y_addr    (wy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_active, n_done, order_err, exp_x, exp_y, saved;
  logic [8:0] pix [NP];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (wa === 1'b1) begin
        if (wx != 32'(exp_x) || wy != 32'(exp_y)) order_err++;
        if (wx < 32'(W) && wy < 32'(H)) pix[int'(wy) * W + int'(wx)] = wc;
        n_active++;
        if (exp_x == W - 1) begin
          exp_x = 0;
          exp_y++;
        end else begin
          exp_x++;
        end
      end
      if (bus.frame_done === 1'b1) n_done++;
    end
  end

  task automatic clear_mon();
    n_active  = 0;
    n_done    = 0;
    order_err = 0;
    exp_x     = 0;
    exp_y     = 0;
    for (int i = 0; i < NP; i++) pix[i] = UNSET;
  endtask

  task automatic pix_is(input string tag, input int x, input int y, input logic [8:0] exp);
    check_val(tag, 32'(pix[y * W + x]), 32'(exp));
  endtask

  task automatic request();
    @(posedge clk);
    #1 bus.write_awaited = 1'b1;
    @(posedge clk);
    #1 bus.write_awaited = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && n_done == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_checks(input string tag);
    check_val({tag, "_active"}, 32'(n_active), 32'(NP));
    check_val({tag, "_order"}, 32'(order_err), 32'd0);
    check_val({tag, "_done"}, 32'(n_done), 32'd1);
  endtask

  task automatic run_frame(input string tag);
    clear_mon();
    request();
    wait_done();
    frame_checks(tag);
  endtask

  initial begin
    bus.write_source_sel = 2'd0;
    bus.write_awaited    = 1'b0;
    tax  = '0;
    tay  = '0;
    tdx  = '0;
    tdy  = '0;
    men  = 2'b01;
    mcol = {C1, C0};
    clear_mon();

    #1;
    check_val("rst_active", 32'(wa), 32'd0);
    check_val("rst_xaddr", wx, 32'd0);
    check_val("rst_done", 32'(bus.frame_done), 32'd0);
    #20 resetN = 1'b1;

    // Centred mark on channel 0 only
    run_frame("f_centre");
    pix_is("f_centre_mark", 31, 23, C0);
    pix_is("f_centre_crossrow", 0, 23, CROSS);
    pix_is("f_centre_crosscol", 32, 5, CROSS);
    pix_is("f_centre_bg", 0, 0, BG);
    pix_is("f_centre_bgcorner", 63, 47, BG);

    // +X offset of 5<<1: cx=42, cy=24
    tax = 8'h05;
    tdx = 2'b01;
    run_frame("f_posx");
    pix_is("f_posx_edge", 52, 14, C0);
    pix_is("f_posx_outside", 53, 14, BG);
    pix_is("f_posx_left", 22, 14, BG);
    pix_is("f_posx_centre", 42, 24, C0);

    // Clamp both axes: cx=32-30 -> 10, cy=24+30 -> 37
    tax = 8'h0F;
    tdx = 2'b00;
    tay = 8'h0F;
    tdy = 2'b01;
    run_frame("f_clamp");
    pix_is("f_clamp_tl", 0, 27, C0);
    pix_is("f_clamp_br", 20, 47, C0);
    pix_is("f_clamp_right", 21, 27, BG);
    pix_is("f_clamp_above", 0, 26, BG);

    // Overlapping marks: channel 0 wins, then channel 1 alone
    tax  = '0;
    tay  = '0;
    tdy  = '0;
    men  = 2'b11;
    run_frame("f_both");
    pix_is("f_both_centre", 32, 24, C0);
    pix_is("f_both_edge", 42, 34, C0);
    men = 2'b10;
    run_frame("f_ch1");
    pix_is("f_ch1_centre", 32, 24, C1);
    pix_is("f_ch1_bg", 0, 0, BG);

    // Tilt changed mid-frame must not move the latched mark
    men = 2'b01;
    tax = 8'h05;
    tdx = 2'b01;
    clear_mon();
    request();
    repeat (100) @(posedge clk);
    #1 tax = 8'h00;
    wait_done();
    frame_checks("f_latch");
    pix_is("f_latch_old", 52, 30, C0);
    pix_is("f_latch_new", 22, 30, BG);

    // Losing the bus mid-frame aborts without frame_done
    clear_mon();
    request();
    repeat (200) @(posedge clk);
    #1 bus.write_source_sel = 2'd1;
    #1 check_val("abort_released", 32'(wa === 1'b1), 32'd0);
    repeat (3) @(posedge clk);
    #1 bus.write_source_sel = 2'd0;
    saved = n_active;
    repeat (50) @(negedge clk);
    check_val("abort_idle", 32'(n_active), 32'(saved));
    check_val("abort_nodone", 32'(n_done), 32'd0);
    check_val("abort_partial", 32'(n_active > 100 && n_active < 300), 32'd1);

    // Asynchronous reset at pixel 1000, then a clean frame
    clear_mon();
    request();
    for (int i = 0; i < 2000 && n_active < 1000; i++) @(negedge clk);
    check_val("rst_reached", 32'(n_active), 32'd1000);
    resetN = 1'b0;
    #1;
    check_val("rst_mid_active", 32'(wa), 32'd0);
    check_val("rst_mid_x", wx, 32'd0);
    check_val("rst_mid_y", wy, 32'd0);
    check_val("rst_mid_done", 32'(bus.frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    saved = n_active;
    repeat (50) @(negedge clk);
    check_val("rst_idle", 32'(n_active), 32'(saved));
    check_val("rst_nodone", 32'(n_done), 32'd0);
    tax = '0;
    run_frame("f_after_rst");
    pix_is("f_after_rst_first", 0, 0, BG);
    pix_is("f_after_rst_mark", 32, 24, C0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gsens_mark_draw.md
GSENS_MARK_DRAW -- requirements
Module: gsens_mark_draw

Interface
REQ-001 SHALL have parameters: SOURCE_ID, default 0, bus-source index of this block; SEL_WIDTH, default 2, width of write_source_sel; COLOR_DEPTH, default 9, pixel colour width.
REQ-002 SHALL have parameters: DRAW_WIDTH, default 640, frame columns; DRAW_HEIGHT, default 480, frame rows.
REQ-003 SHALL have parameters: NUM_MARKS, default 2, tilt channels drawn (1..4); TILT_WIDTH, default 4, magnitude bits per axis; TILT_SCALE, default 1, left-shift applied to magnitude; MARK_SIZE, default 10, mark half-extent in pixels.
REQ-004 SHALL have parameters: CROSS_COLOR, default all-ones, crosshair colour; BG_COLOR, default 0, background colour.
REQ-005 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- write_source_sel  in  SEL_WIDTH  index of the source owning the write bus
- write_awaited  in  1  arbiter requests a frame
- tilt_amount_x  in  NUM_MARKS*TILT_WIDTH  per-channel X magnitude; channel i at bits [i*TILT_WIDTH +: TILT_WIDTH]
- tilt_direction_x  in  NUM_MARKS  1 = positive X offset
- tilt_amount_y  in  NUM_MARKS*TILT_WIDTH  per-channel Y magnitude
- tilt_direction_y  in  NUM_MARKS  1 = positive Y offset
- mark_enable  in  NUM_MARKS  per-channel draw enable
- mark_color  in  NUM_MARKS*COLOR_DEPTH  per-channel mark colour
- write_active  out  1  pixel valid on the bus this cycle
- write_color_data  out  COLOR_DEPTH  pixel colour
- write_x_addr  out  32  pixel column
- write_y_addr  out  32  pixel row
- frame_done  out  1  one-cycle pulse after the last pixel
REQ-006 When write_source_sel != SOURCE_ID, write_active, write_color_data, write_x_addr and write_y_addr SHALL be high-impedance; frame_done SHALL always be driven.

Function
REQ-007 The FSM SHALL have states IDLE, LATCH, WRITE, DONE.
REQ-008 IDLE->LATCH when write_awaited=1 and write_source_sel==SOURCE_ID; else hold IDLE.
REQ-009 LATCH (1 cycle) SHALL snapshot all tilt, enable and colour inputs, compute mark centres, and zero column/row; then LATCH->WRITE.
REQ-010 Input changes after LATCH SHALL NOT affect the frame in progress.
REQ-011 Mark centre per channel SHALL be cx = DRAW_WIDTH/2 +/- (amount << TILT_SCALE) and cy = DRAW_HEIGHT/2 +/- (amount << TILT_SCALE), using signed arithmetic of at least 16 bits.
REQ-012 cx SHALL be clamped to [MARK_SIZE, DRAW_WIDTH-1-MARK_SIZE] and cy to [MARK_SIZE, DRAW_HEIGHT-1-MARK_SIZE].
REQ-013 In WRITE, exactly DRAW_WIDTH*DRAW_HEIGHT consecutive cycles SHALL have write_active=1, raster order: column 0..DRAW_WIDTH-1, then row+1.
REQ-014 write_x_addr, write_y_addr and write_color_data SHALL be registered and aligned, describing the same pixel in the same cycle.
REQ-015 Pixel colour priority, highest first:
- lowest-index enabled channel i with |col-cx_i|<=MARK_SIZE and |row-cy_i|<=MARK_SIZE: mark_color[i]
- col in {DRAW_WIDTH/2-1, DRAW_WIDTH/2} or row in {DRAW_HEIGHT/2-1, DRAW_HEIGHT/2}: CROSS_COLOR
- otherwise: BG_COLOR
REQ-016 After pixel (DRAW_WIDTH-1, DRAW_HEIGHT-1): WRITE->DONE; DONE SHALL pulse frame_done=1 for one cycle with write_active=0, then go to IDLE.
REQ-017 If write_source_sel != SOURCE_ID during LATCH or WRITE, the block SHALL abort to IDLE on the next edge with no frame_done pulse.
REQ-018 A new request arriving in DONE SHALL be accepted only from IDLE, giving a minimum of 2 cycles between frames.
REQ-019 When selected and not in WRITE, write_active SHALL be 0 and address/colour outputs SHALL be 0.

Reset
REQ-020 resetN=0 SHALL asynchronously force the state to IDLE and set column, row, colour, latched centres (to frame centre), frame_done and write_active to 0.
REQ-021 Reset asserted mid-frame SHALL terminate the frame with no frame_done; after release, the block waits in IDLE for a new request.

Verification
REQ-022 Defaults, sel=0, awaited pulse, all tilts 0, mark_enable=01 -> 307200 active cycles; pixel (319,239)=mark_color[0], (0,239)=CROSS_COLOR, (0,0)=BG; one frame_done pulse.
REQ-023 Channel 0 X=15, dir=1, TILT_SCALE=1 -> cx=350; pixel (360,230)=mark colour, (361,230)=BG.
REQ-024 Channel 0 X=15 dir=0 with TILT_SCALE=5 -> centre clamped to cx=10; columns 0..20 marked on rows cy+/-10.
REQ-025 Channels 0 and 1 at equal tilt, both enabled -> overlap pixels show mark_color[0]; disable channel 0 -> mark_color[1].
REQ-026 Change tilt mid-frame -> remaining pixels use the latched centres.
REQ-026 (cont.) Switch sel to 1 mid-frame -> outputs go Z, FSM returns to IDLE, no frame_done.
REQ-027 resetN low at pixel 1000 -> all outputs 0 immediately, no frame_done; re-request -> full frame from (0,0).
